// File: rtl/sram22_arbiter.sv
// sram22_arbiter: round-robin arbiter sharing one single-port SRAM between two requesters
module sram22_arbiter #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 128,
    parameter int WMASK_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   a_req_valid,
    output logic                   a_req_ready,
    input  logic                   a_req_we,
    input  logic [WMASK_WIDTH-1:0] a_req_wmask,
    input  logic [ADDR_WIDTH-1:0]  a_req_addr,
    input  logic [DATA_WIDTH-1:0]  a_req_wdata,
    output logic                   a_resp_valid,
    output logic [DATA_WIDTH-1:0]  a_resp_rdata,
    input  logic                   b_req_valid,
    output logic                   b_req_ready,
    input  logic                   b_req_we,
    input  logic [WMASK_WIDTH-1:0] b_req_wmask,
    input  logic [ADDR_WIDTH-1:0]  b_req_addr,
    input  logic [DATA_WIDTH-1:0]  b_req_wdata,
    output logic                   b_resp_valid,
    output logic [DATA_WIDTH-1:0]  b_resp_rdata,
    output logic                   sram_ce,
    output logic                   sram_we,
    output logic                   sram_rstb,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);
    logic prio;
    logic v0, v1, t0, t1;
    logic gnt_b;

    // prio=0 favours A, prio=1 favours B when both are valid
    always_comb begin
        a_req_ready  = rstb & a_req_valid & (~b_req_valid | ~prio);
        b_req_ready  = rstb & b_req_valid & (~a_req_valid | prio);
        gnt_b        = b_req_ready;
        sram_ce      = a_req_ready | b_req_ready;
        sram_we      = sram_ce & (gnt_b ? b_req_we : a_req_we);
        sram_wmask   = sram_ce ? (gnt_b ? b_req_wmask : a_req_wmask) : '0;
        sram_addr    = gnt_b ? b_req_addr : a_req_addr;
        sram_din     = gnt_b ? b_req_wdata : a_req_wdata;
        sram_rstb    = rstb;
        a_resp_valid = rstb & v1 & ~t1;
        b_resp_valid = rstb & v1 & t1;
    end

    // v0/t0: read issued last cycle, dout valid now; v1/t1: response cycle
    always_ff @(posedge clk) begin
        if (!rstb) begin
            v0           <= 1'b0;
            v1           <= 1'b0;
            prio         <= 1'b0;
            a_resp_rdata <= '0;
            b_resp_rdata <= '0;
        end else begin
            v0 <= sram_ce & ~sram_we;
            t0 <= gnt_b;
            v1 <= v0;
            t1 <= t0;
            if (sram_ce) prio <= ~gnt_b;
            if (v0 & ~t0) a_resp_rdata <= sram_dout;
            if (v0 & t0) b_resp_rdata <= sram_dout;
        end
    end
endmodule

// File: tb/tb_sram22_arbiter.sv
// tb_sram22_arbiter: table, directed and random checks against a behavioural model
module tb_sram22_arbiter;
    localparam int AW = 8;
    localparam int DW = 128;
    localparam int MW = 16;

    logic          clk = 0;
    logic          rstb = 0;
    logic          a_req_valid = 0, a_req_we = 0, b_req_valid = 0, b_req_we = 0;
    logic [MW-1:0] a_req_wmask = 0, b_req_wmask = 0;
    logic [AW-1:0] a_req_addr = 0, b_req_addr = 0;
    logic [DW-1:0] a_req_wdata = 0, b_req_wdata = 0;
    logic          a_req_ready, b_req_ready, a_resp_valid, b_resp_valid;
    logic [DW-1:0] a_resp_rdata, b_resp_rdata;
    logic          sram_ce, sram_we, sram_rstb;
    logic [MW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din, sram_dout;

    always #5 clk = ~clk;

    sram22_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW)) dut (
        .clk(clk), .rstb(rstb),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_wmask(a_req_wmask), .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
        .a_resp_valid(a_resp_valid), .a_resp_rdata(a_resp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_wmask(b_req_wmask), .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
        .b_resp_valid(b_resp_valid), .b_resp_rdata(b_resp_rdata),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_rstb(sram_rstb),
        .sram_wmask(sram_wmask), .sram_addr(sram_addr), .sram_din(sram_din),
        .sram_dout(sram_dout)
    );

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r = old;
        for (int i = 0; i < MW; i++) if (m[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    // SRAM macro: registered read port, byte-masked write
    logic [DW-1:0] sram [0:(1<<AW)-1];
    always @(posedge clk)
        if (sram_ce) begin
            if (sram_we) sram[sram_addr] <= merge(sram[sram_addr], sram_din, sram_wmask);
            else sram_dout <= sram[sram_addr];
        end

    // reference model: memory image, priority bit, queue of pending responses
    typedef struct { bit port; logic [DW-1:0] data; int due; } resp_t;
    resp_t         q[$];
    logic [DW-1:0] m_mem [0:(1<<AW)-1];
    logic [DW-1:0] m_rd [2];
    bit            m_prio = 0;
    int            cyc = 0;
    int            n_pass = 0, n_tot = 0;
    logic          s_ar, s_br, s_arv, s_brv;
    logic [DW-1:0] s_ard, s_brd;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        bit ga, gb, due_now;
        @(negedge clk);
        ga = 0; gb = 0;
        if (rstb) begin
            if (a_req_valid && b_req_valid) begin ga = !m_prio; gb = m_prio; end
            else begin ga = a_req_valid; gb = b_req_valid; end
        end
        due_now = rstb && q.size() > 0 && q[0].due == cyc;
        chk("a_req_ready", a_req_ready, ga);
        chk("b_req_ready", b_req_ready, gb);
        chk("sram_ce", sram_ce, ga | gb);
        chk("sram_rstb", sram_rstb, rstb);
        chk("sram_we", sram_we, ga ? a_req_we : gb ? b_req_we : 1'b0);
        chk("sram_wmask", sram_wmask, ga ? a_req_wmask : gb ? b_req_wmask : '0);
        if (ga | gb) begin
            chk("sram_addr", sram_addr, ga ? a_req_addr : b_req_addr);
            chk("sram_din", sram_din, ga ? a_req_wdata : b_req_wdata);
        end
        chk("a_resp_valid", a_resp_valid, due_now && !q[0].port);
        chk("b_resp_valid", b_resp_valid, due_now && q[0].port);
        chk("a_resp_rdata", a_resp_rdata, m_rd[0]);
        chk("b_resp_rdata", b_resp_rdata, m_rd[1]);
        s_ar = a_req_ready; s_br = b_req_ready; s_arv = a_resp_valid; s_brv = b_resp_valid;
        s_ard = a_resp_rdata; s_brd = b_resp_rdata;
        @(posedge clk);
        if (!rstb) begin
            q.delete(); m_prio = 0; m_rd[0] = '0; m_rd[1] = '0;
        end else begin
            foreach (q[i]) if (q[i].due == cyc + 1) m_rd[q[i].port] = q[i].data;
            if (due_now) void'(q.pop_front());
            if (ga) begin
                if (a_req_we) m_mem[a_req_addr] = merge(m_mem[a_req_addr], a_req_wdata, a_req_wmask);
                else q.push_back('{0, m_mem[a_req_addr], cyc + 2});
                m_prio = 1;
            end else if (gb) begin
                if (b_req_we) m_mem[b_req_addr] = merge(m_mem[b_req_addr], b_req_wdata, b_req_wmask);
                else q.push_back('{1, m_mem[b_req_addr], cyc + 2});
                m_prio = 0;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic req(input bit p, input logic v, input logic we, input logic [MW-1:0] m,
                       input logic [AW-1:0] ad, input logic [DW-1:0] d);
        if (!p) begin
            a_req_valid = v; a_req_we = we; a_req_wmask = m; a_req_addr = ad; a_req_wdata = d;
        end else begin
            b_req_valid = v; b_req_we = we; b_req_wmask = m; b_req_addr = ad; b_req_wdata = d;
        end
    endtask

    task automatic idle();
        req(0, 0, 0, '0, '0, '0);
        req(1, 0, 0, '0, '0, '0);
    endtask

    typedef struct { logic rst_n, av, bv, ear, ebr; } vec_t;
    vec_t tbl[18];
    localparam logic [DW-1:0] D39 = 128'h0123456789ABCDEF0123456789ABCDEF;

    initial begin
        m_rd[0] = '0; m_rd[1] = '0;
        tbl[0]  = '{0, 1, 1, 0, 0};
        for (int i = 1; i <= 6; i++) tbl[i] = '{1, 1, 1, i % 2, 1 - i % 2};
        for (int i = 7; i <= 10; i++) tbl[i] = '{1, 0, 1, 0, 1};
        tbl[11] = '{1, 1, 1, 1, 0};
        tbl[12] = '{1, 0, 0, 0, 0};
        tbl[13] = '{1, 1, 1, 0, 1};
        tbl[14] = '{1, 1, 0, 1, 0};
        tbl[15] = '{1, 1, 1, 0, 1};
        tbl[16] = '{0, 1, 1, 0, 0};
        tbl[17] = '{1, 1, 1, 1, 0};
        rstb = 0;
        repeat (2) @(posedge clk);
        #1;
        // arbitration table: writes only, so grants are checked in isolation
        foreach (tbl[i]) begin
            rstb = tbl[i].rst_n;
            req(0, tbl[i].av, 1, '1, AW'($urandom_range(0, 7)), {4{$urandom}});
            req(1, tbl[i].bv, 1, '1, AW'($urandom_range(0, 7)), {4{$urandom}});
            tick();
            chk("tbl_a_ready", s_ar, tbl[i].ear);
            chk("tbl_b_ready", s_br, tbl[i].ebr);
            chk("tbl_one_ready", s_ar & s_br, 0);
        end
        idle(); rstb = 1;
        for (int i = 0; i < 8; i++) begin req(0, 1, 1, '1, AW'(i), {4{$urandom}}); tick(); end
        // write then read back on A
        req(0, 1, 1, '1, 8'h10, D39); tick();
        req(0, 1, 0, '0, 8'h10, '0); tick(); chk("r39_accept", s_ar, 1);
        idle(); tick(); chk("r39_early", s_arv, 0);
        tick(); chk("r39_valid", s_arv, 1); chk("r39_data", s_ard, D39); chk("r39_b_quiet", s_brv, 0);
        tick(); chk("r39_once", s_arv, 0); chk("r39_hold", s_ard, D39);
        // partial byte write
        req(1, 1, 1, '1, 8'h20, '1); tick();
        req(1, 1, 1, 16'h0001, 8'h20, '0); tick();
        req(1, 1, 0, '0, 8'h20, '0); tick();
        idle(); tick(); tick();
        chk("r41_valid", s_brv, 1); chk("r41_data", s_brd, {{(DW-8){1'b1}}, 8'h00});
        // back-to-back reads alternating ports
        for (int i = 1; i <= 3; i++) begin req(0, 1, 1, '1, AW'(i), DW'(i * 32'h1111)); tick(); end
        req(0, 1, 0, '0, 8'd1, '0); tick(); idle();
        req(1, 1, 0, '0, 8'd2, '0); tick(); idle();
        req(0, 1, 0, '0, 8'd3, '0); tick(); idle();
        chk("r42_first_a", s_arv, 1); chk("r42_first_d", s_ard, DW'(32'h1111));
        tick(); chk("r42_second_b", s_brv, 1); chk("r42_second_d", s_brd, DW'(32'h2222));
        chk("r42_second_not_a", s_arv, 0);
        tick(); chk("r42_third_a", s_arv, 1); chk("r42_third_d", s_ard, DW'(32'h3333));
        tick();
        // read dropped by reset; priority back to A
        req(1, 1, 1, '1, 8'd5, '0); tick();
        idle(); req(0, 1, 0, '0, 8'd1, '0); tick(); chk("r43_accept", s_ar, 1);
        idle(); rstb = 0; tick(); rstb = 1;
        for (int i = 0; i < 3; i++) begin tick(); chk("r43_dropped", s_arv | s_brv, 0); end
        req(0, 1, 1, '1, 8'd6, '0); req(1, 1, 1, '1, 8'd7, '0); tick();
        chk("r43_prio_a", s_ar, 1); chk("r43_prio_not_b", s_br, 0);
        // random traffic
        for (int i = 0; i < 500; i++) begin
            rstb = $urandom_range(0, 39) != 0;
            req(0, 1'($urandom), 1'($urandom), MW'($urandom), AW'($urandom_range(0, 7)), {4{$urandom}});
            req(1, 1'($urandom), 1'($urandom), MW'($urandom), AW'($urandom_range(0, 7)), {4{$urandom}});
            tick();
        end
        idle(); rstb = 1;
        repeat (4) tick();
        chk("drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
